fixed_mul_arbiter: RTL and testbench



---
 rtl/fixed_mul_arb_pkg.sv | 22 ++
 rtl/fixed_mul_arb_tag_fifo.sv | 52 +++++
 rtl/fixed_mul_arbiter.sv | 129 ++++++++++++
 tb/tb_fixed_mul_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_mul_arb_pkg.sv
// Shared widths and elaboration-time helpers for the fixed-point multiplier arbiter.
package fixed_mul_arb_pkg;

  localparam int OPERAND_W = 64;
  localparam int RESULT_W  = 32;

  // Index width for a value range of 0..value-1, never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // The tag count must represent 0..depth inclusive.
  function automatic int tag_count_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fixed_mul_arb_tag_fifo.sv
// Synchronous FIFO of requester indices.
// Records which requester owns each in-flight multiply, in issue order.
module fixed_mul_arb_tag_fifo
  import fixed_mul_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = tag_count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic [IDX_W-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = clog2(DEPTH);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the pointers wrap naturally.
  assign do_push = push & (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop & (count_q != '0);

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_idx;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fixed_mul_arbiter.sv
// Shares one pipelined 26.6 fixed-point multiplier between NUM_REQ requesters.
// Define FIXED_MUL_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module fixed_mul_arbiter
  import fixed_mul_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [NUM_REQ-1:0]            reqReady,
  input  logic [OPERAND_W*NUM_REQ-1:0]  reqData,
  output logic [NUM_REQ-1:0]            reqStop,
  output logic [NUM_REQ-1:0]            rspReady,
  output logic [RESULT_W*NUM_REQ-1:0]   rspData,
  input  logic [NUM_REQ-1:0]            rspStop,
  output logic                          mulOperandsReady,
  output logic [OPERAND_W-1:0]          mulOperandsData,
  input  logic                          mulOperandsStop,
  input  logic                          mulResultReady,
  input  logic [RESULT_W-1:0]           mulResultData,
  output logic                          mulResultStop
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = tag_count_width(TAG_DEPTH);

  logic                 issue_valid_q;
  logic [OPERAND_W-1:0] issue_data_q;
  logic                 can_load;
  logic                 found;
  logic                 grant;
  logic                 pop;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     head;
  logic [CNT_W-1:0]     tag_count;
  logic [OPERAND_W-1:0] win_data;

  assign can_load = ~issue_valid_q | ~mulOperandsStop;

`ifdef FIXED_MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && reqReady[k]) begin
        winner = IDX_W'(k);
        found  = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W:0]   cand;

  // Search starts at the pointer and wraps modulo NUM_REQ (need not be a power of two).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && reqReady[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      rr_ptr_q <= '0;
    else if (grant)
      rr_ptr_q <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
  end
`endif

  assign grant = found & can_load & (tag_count < CNT_W'(TAG_DEPTH)) & ~srst;

  always_comb begin
    reqStop  = '1;
    win_data = '0;
    if (grant) reqStop[winner] = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == IDX_W'(k)) win_data = reqData[OPERAND_W*k +: OPERAND_W];
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      issue_valid_q <= 1'b0;
    else if (can_load)
      issue_valid_q <= grant;
  end

  always_ff @(posedge clk) begin
    if (grant) issue_data_q <= win_data;
  end

  assign mulOperandsReady = issue_valid_q;
  assign mulOperandsData  = issue_data_q;

  // A result with no recorded owner, or arriving during reset, is held and never routed.
  assign mulResultStop = srst | (tag_count == '0) | rspStop[head];
  assign pop           = mulResultReady & ~mulResultStop;

  always_comb begin
    rspReady = '0;
    if (mulResultReady && (tag_count != '0) && !srst) rspReady[head] = 1'b1;
  end

  assign rspData = {NUM_REQ{mulResultData}};

  fixed_mul_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .srst     (srst),
    .push     (grant),
    .push_idx (winner),
    .pop      (pop),
    .head     (head),
    .count    (tag_count)
  );

endmodule

// File: tb/tb_fixed_mul_arbiter.sv
// Randomized scoreboard bench for fixed_mul_arbiter with a latency-modelled multiplier.
// Honours FIXED_MUL_ARB_FIXED_PRIO_EN for the expected arbitration rule.
module tb_fixed_mul_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int TAG_DEPTH = 4;
  localparam int MUL_LAT   = 2;

  logic                    clk = 1'b0;
  logic                    srst;
  logic [NUM_REQ-1:0]      reqReady;
  logic [64*NUM_REQ-1:0]   reqData;
  logic [NUM_REQ-1:0]      reqStop;
  logic [NUM_REQ-1:0]      rspReady;
  logic [32*NUM_REQ-1:0]   rspData;
  logic [NUM_REQ-1:0]      rspStop;
  logic                    mulOperandsReady;
  logic [63:0]             mulOperandsData;
  logic                    mulOperandsStop;
  logic                    mulResultReady;
  logic [31:0]             mulResultData;
  logic                    mulResultStop;

  always #5 clk = ~clk;

  fixed_mul_arbiter #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk              (clk),
    .srst             (srst),
    .reqReady         (reqReady),
    .reqData          (reqData),
    .reqStop          (reqStop),
    .rspReady         (rspReady),
    .rspData          (rspData),
    .rspStop          (rspStop),
    .mulOperandsReady (mulOperandsReady),
    .mulOperandsData  (mulOperandsData),
    .mulOperandsStop  (mulOperandsStop),
    .mulResultReady   (mulResultReady),
    .mulResultData    (mulResultData),
    .mulResultStop    (mulResultStop)
  );

  typedef struct { int req; logic [31:0] res; } exp_t;
  typedef struct { logic [31:0] res; int due; } mul_t;

  exp_t sb[$];
  mul_t mulPipe[$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic        pending  [NUM_REQ];
  logic [63:0] pendData [NUM_REQ];
  int          occ;
  logic [63:0] issueData;
  int          rrNext;

  logic [NUM_REQ-1:0] enMask;
  int                 reqProb, rspStopProb, mulStopProb;
  logic               holdRsp, spurious, rstReq, dataMode;
  logic [31:0]        fixA, fixB;

  // 26.6 signed product: full 64-bit product, arithmetic shift by 6, keep low 32 bits.
  function automatic logic [31:0] fixMul(input logic [63:0] ops);
    longint a, b, p;
    a = longint'(signed'(ops[31:0]));
    b = longint'(signed'(ops[63:32]));
    p = (a * b) >>> 6;
    return p[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cycle, act, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    int                 expWin;
    logic [NUM_REQ-1:0] expStop, expRsp;
    logic               expMStop, canLoad, mulIn, mulOut;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cycle++;
      srst = rstReq;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pending[i] && enMask[i] && ($urandom_range(99) < reqProb)) begin
          pending[i]  = 1'b1;
          pendData[i] = dataMode ? {fixB, fixA} : {$urandom(), $urandom()};
        end
        reqReady[i]        = pending[i];
        reqData[64*i +: 64] = pendData[i];
        rspStop[i]         = holdRsp || ($urandom_range(99) < rspStopProb);
      end
      mulOperandsStop = ($urandom_range(99) < mulStopProb);
      if (mulPipe.size() != 0 && mulPipe[0].due <= cycle) begin
        mulResultReady = 1'b1;
        mulResultData  = mulPipe[0].res;
      end else if (spurious) begin
        mulResultReady = 1'b1;
        mulResultData  = 32'hDEADBEEF;
      end else begin
        mulResultReady = 1'b0;
        mulResultData  = $urandom();
      end
      #1;
      if (srst) begin
        checkOutput("reqStopInReset", reqStop, {NUM_REQ{1'b1}});
        sb.delete();
        mulPipe.delete();
        occ    = 0;
        rrNext = 0;
        for (int i = 0; i < NUM_REQ; i++) pending[i] = 1'b0;
      end else begin
        expWin  = -1;
        canLoad = (occ == 0) || !mulOperandsStop;
        if (canLoad && sb.size() < TAG_DEPTH) begin
`ifdef FIXED_MUL_ARB_FIXED_PRIO_EN
          for (int k = 0; k < NUM_REQ; k++)
            if (expWin < 0 && pending[k]) expWin = k;
`else
          for (int k = 0; k < NUM_REQ; k++)
            if (expWin < 0 && pending[(rrNext + k) % NUM_REQ]) expWin = (rrNext + k) % NUM_REQ;
`endif
        end
        expStop = '1;
        if (expWin >= 0) expStop[expWin] = 1'b0;
        checkOutput("reqStop", reqStop, expStop);
        checkOutput("mulOperandsReady", mulOperandsReady, occ != 0);
        if (occ != 0) checkOutput("mulOperandsData", mulOperandsData, issueData);
        expRsp   = '0;
        expMStop = 1'b1;
        if (sb.size() != 0) begin
          expMStop = rspStop[sb[0].req];
          if (mulResultReady) expRsp[sb[0].req] = 1'b1;
        end
        checkOutput("mulResultStop", mulResultStop, expMStop);
        checkOutput("rspReady", rspReady, expRsp);

        mulIn  = mulOperandsReady && !mulOperandsStop;
        mulOut = mulResultReady && !mulResultStop;
        if (mulOut) begin
          if (mulPipe.size() == 0 || mulPipe[0].due > cycle) begin
            checks++;
            errors++;
            $display("[TB] FAIL unownedResultTaken cycle=%0d got=taken expected=held", cycle);
          end else begin
            void'(mulPipe.pop_front());
          end
        end
        if (mulIn) begin
          mulPipe.push_back('{res: fixMul(mulOperandsData), due: cycle + MUL_LAT});
          occ--;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (reqReady[i] && !reqStop[i]) begin
            sb.push_back('{req: i, res: fixMul(pendData[i])});
            issueData  = pendData[i];
            occ++;
            pending[i] = 1'b0;
            rrNext     = (i + 1) % NUM_REQ;
          end
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a requester actually takes a result.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!srst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rspReady[i] && !rspStop[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rspWithoutRequest cycle=%0d got=req%0d expected=none", cycle, i);
          end else begin
            e = sb.pop_front();
            checkOutput("rspRequester", i, e.req);
            checkOutput("rspData", rspData[32*i +: 32], e.res);
          end
        end
      end
    end
  end

  initial begin
    int anyPending;
    srst = 1'b1; reqReady = '0; reqData = '0; rspStop = '0;
    mulOperandsStop = 1'b0; mulResultReady = 1'b0; mulResultData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin pending[i] = 1'b0; pendData[i] = '0; end
    occ = 0; issueData = '0; rrNext = 0;
    enMask = '0; reqProb = 0; rspStopProb = 0; mulStopProb = 0;
    holdRsp = 1'b0; spurious = 1'b0; dataMode = 1'b1; fixA = '0; fixB = '0;

    $display("[TB] reset and unowned result");
    rstReq = 1'b1; applyStimulus(3);
    rstReq = 1'b0; spurious = 1'b1; applyStimulus(4);
    spurious = 1'b0;

    $display("[TB] single op 2.0 x 3.0 on req0");
    fixA = 32'h00000080; fixB = 32'h000000C0; enMask = 4'b0001;
    reqProb = 100; applyStimulus(1);
    reqProb = 0;   applyStimulus(8);

    $display("[TB] all requesters, -1.5 x 2.0, then result hold");
    fixA = 32'hFFFFFFA0; fixB = 32'h00000080; enMask = 4'hF; reqProb = 100;
    applyStimulus(20);
    holdRsp = 1'b1; applyStimulus(10);
    holdRsp = 1'b0; applyStimulus(10);

    $display("[TB] reset with ops outstanding");
    holdRsp = 1'b1; applyStimulus(3);
    rstReq = 1'b1; applyStimulus(1);
    rstReq = 1'b0; holdRsp = 1'b0; enMask = 4'b0100; fixA = 32'h00000040; fixB = 32'hFFFFFF00;
    reqProb = 100; applyStimulus(1);
    reqProb = 0;   applyStimulus(8);

    $display("[TB] req0 and req2 always ready");
    dataMode = 1'b0; enMask = 4'b0101; reqProb = 100; applyStimulus(30);

    $display("[TB] random traffic with backpressure");
    enMask = 4'hF; reqProb = 40; rspStopProb = 25; mulStopProb = 25;
    applyStimulus(1500);

    enMask = '0; reqProb = 0; rspStopProb = 0; mulStopProb = 0;
    for (int t = 0; t < 200; t++) begin
      anyPending = 0;
      for (int i = 0; i < NUM_REQ; i++) if (pending[i]) anyPending = 1;
      if (sb.size() == 0 && anyPending == 0) break;
      applyStimulus(1);
    end
    checkOutput("drainOutstanding", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
